// File: rtl/fp_pkg.sv
// Shared types and widths for the fraction normalizer datapath.
// Holds the float field widths, FSM state encoding and packed result layout.
package fp_pkg;

   localparam int FRAC_W = 6;
   localparam int EXP_W  = 4;
   localparam int TF_W   = FRAC_W + 1;
   localparam int RES_W  = 1 + EXP_W + FRAC_W - 1;

   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [EXP_W-1:0] EXP_OVF = EXP_MAX - EXP_W'(1);
   localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } norm_state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-2:0] frac;
   } fp_word_t;

endpackage

// File: rtl/frac_normalizer.sv
// Iterative normalizer: shifts the ALU magnitude one bit per cycle until
// the hidden bit is set, then publishes {sign, exp, frac} with flags.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   IN_VALID/IN_READY        operand handshake (TEMP_FRAC, RESULT_SIGN, EXP_IN)
//   OUT_VALID/OUT_READY      result handshake (RESULT, ZERO, OVERFLOW, UNDERFLOW)
module frac_normalizer
   import fp_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [TF_W-1:0]  TEMP_FRAC,
   input  logic             RESULT_SIGN,
   input  logic [EXP_W-1:0] EXP_IN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [RES_W-1:0] RESULT,
   output logic             ZERO,
   output logic             OVERFLOW,
   output logic             UNDERFLOW
);

   norm_state_t r_state;
   norm_state_t w_state_nxt;

   logic [TF_W-1:0]  r_frac;
   logic [EXP_W-1:0] r_exp;
   logic             r_sign;
   logic             r_zf;
   logic             r_of;
   logic             r_uf;

   fp_word_t         r_result;
   logic             r_out_valid;
   logic             r_zero;
   logic             r_ovf;
   logic             r_unf;

   logic w_accept;
   logic w_is_zero;
   logic w_carry;
   logic w_norm;
   logic w_small;
   logic w_at_ovf;
   logic w_at_unf;
   logic w_finish;

   // Exactly one of the four classes is true for any working fraction.
   assign w_is_zero = (r_frac == '0);
   assign w_carry   = r_frac[TF_W-1];
   assign w_norm    = !r_frac[TF_W-1] && r_frac[TF_W-2];
   assign w_small   = !r_frac[TF_W-1] && !r_frac[TF_W-2] && !w_is_zero;

   assign w_at_ovf  = (r_exp == EXP_OVF);
   // Exponent 0 with a nonzero fraction counts as 1 here.
   assign w_at_unf  = (r_exp <= EXP_ONE);

   assign w_finish  = w_is_zero
                    || (w_carry && w_at_ovf)
                    || w_norm
                    || (w_small && w_at_unf);

   assign w_accept  = IN_VALID && IN_READY;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = NORM;
            end
         end
         NORM: begin
            if (w_finish) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (r_out_valid && OUT_READY) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      IN_READY  = (r_state == IDLE) && !RST;
      OUT_VALID = r_out_valid;
      RESULT    = r_result;
      ZERO      = r_zero;
      OVERFLOW  = r_ovf;
      UNDERFLOW = r_unf;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_frac      <= '0;
         r_exp       <= '0;
         r_sign      <= 1'b0;
         r_zf        <= 1'b0;
         r_of        <= 1'b0;
         r_uf        <= 1'b0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_frac   <= TEMP_FRAC;
                  r_exp    <= EXP_IN;
                  r_sign   <= RESULT_SIGN;
                  r_zf     <= 1'b0;
                  r_of     <= 1'b0;
                  r_uf     <= 1'b0;
                  r_result <= '0;
                  r_zero   <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_unf    <= 1'b0;
               end
            end
            NORM: begin
               unique case (1'b1)
                  w_is_zero: begin
                     r_exp  <= '0;
                     r_sign <= 1'b0;
                     r_zf   <= 1'b1;
                  end
                  w_carry: begin
                     if (w_at_ovf) begin
                        r_of   <= 1'b1;
                        r_exp  <= EXP_MAX;
                        r_frac <= '0;
                     end else begin
                        // Truncating right shift absorbs the carry bit.
                        r_frac <= {1'b0, r_frac[TF_W-1:1]};
                        r_exp  <= r_exp + EXP_ONE;
                     end
                  end
                  w_norm: begin
                  end
                  w_small: begin
                     if (w_at_unf) begin
                        r_uf   <= 1'b1;
                        r_frac <= '0;
                        r_exp  <= '0;
                        r_sign <= 1'b0;
                     end else begin
                        r_frac <= {r_frac[TF_W-2:0], 1'b0};
                        r_exp  <= r_exp - EXP_ONE;
                     end
                  end
               endcase
            end
            DONE: begin
               // First DONE cycle publishes; results then hold until taken.
               if (!r_out_valid) begin
                  r_out_valid   <= 1'b1;
                  r_result.sign <= r_sign;
                  r_result.exp  <= r_exp;
                  r_result.frac <= r_frac[FRAC_W-2:0];
                  r_zero        <= r_zf;
                  r_ovf         <= r_of;
                  r_unf         <= r_uf;
               end else if (OUT_READY) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frac_normalizer.sv
// Directed-vector bench for frac_normalizer.
// Checks results, flags, latency, back-pressure and mid-operation reset.
module tb_frac_normalizer;
   import fp_pkg::*;

   logic             CLK;
   logic             RST;
   logic             IN_VALID;
   logic             IN_READY;
   logic [TF_W-1:0]  TEMP_FRAC;
   logic             RESULT_SIGN;
   logic [EXP_W-1:0] EXP_IN;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [RES_W-1:0] RESULT;
   logic             ZERO;
   logic             OVERFLOW;
   logic             UNDERFLOW;

   int n_chk;
   int n_fail;

   frac_normalizer dut (
      .CLK         (CLK),
      .RST         (RST),
      .IN_VALID    (IN_VALID),
      .IN_READY    (IN_READY),
      .TEMP_FRAC   (TEMP_FRAC),
      .RESULT_SIGN (RESULT_SIGN),
      .EXP_IN      (EXP_IN),
      .OUT_VALID   (OUT_VALID),
      .OUT_READY   (OUT_READY),
      .RESULT      (RESULT),
      .ZERO        (ZERO),
      .OVERFLOW    (OVERFLOW),
      .UNDERFLOW   (UNDERFLOW)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] flags();
      return {29'd0, ZERO, OVERFLOW, UNDERFLOW};
   endfunction

   task automatic send(input logic [6:0] f, input logic s,
                       input logic [3:0] e);
      int n;
      n = 0;
      @(negedge CLK);
      TEMP_FRAC   = f;
      RESULT_SIGN = s;
      EXP_IN      = e;
      IN_VALID    = 1'b1;
      while (!IN_READY && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("in_ready", {31'd0, IN_READY}, 32'd1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (lat < 20) begin
         @(posedge CLK);
         #1;
         lat++;
         if (OUT_VALID) break;
      end
      if (!OUT_VALID) chk("out_timeout", 32'd0, 32'd1);
   endtask

   task automatic run(input string tag, input logic [6:0] f,
                      input logic s, input logic [3:0] e,
                      input logic [9:0] res, input logic [2:0] fl,
                      input int lat_exp);
      int lat;
      send(f, s, e);
      wait_out(lat);
      chk({tag, "_res"}, {22'd0, RESULT}, {22'd0, res});
      chk({tag, "_flg"}, flags(), {29'd0, fl});
      chk({tag, "_lat"}, lat, lat_exp);
      @(posedge CLK);
      #1;
      chk({tag, "_done"}, {31'd0, OUT_VALID}, 32'd0);
   endtask

   initial begin
      int lat;
      n_chk       = 0;
      n_fail      = 0;
      RST         = 1'b1;
      IN_VALID    = 1'b0;
      OUT_READY   = 1'b1;
      TEMP_FRAC   = '0;
      RESULT_SIGN = 1'b0;
      EXP_IN      = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_rdy", {31'd0, IN_READY}, 32'd0);
      chk("rst_ov", {31'd0, OUT_VALID}, 32'd0);
      chk("rst_res", {22'd0, RESULT}, 32'd0);
      chk("rst_flg", flags(), 32'd0);
      RST = 1'b0;
      #1;
      chk("rdy_post_rst", {31'd0, IN_READY}, 32'd1);

      run("c1", 7'b0100000, 1'b0, 4'd7, 10'h0E0, 3'b000, 2);
      run("c2", 7'b1010011, 1'b1, 4'd5, 10'h2C9, 3'b000, 3);
      run("c3", 7'b0000101, 1'b0, 4'd9, 10'h0C8, 3'b000, 5);
      run("zero", 7'b0000000, 1'b1, 4'd9, 10'h000, 3'b100, 2);
      run("unf", 7'b0000001, 1'b0, 4'd3, 10'h000, 3'b001, 4);
      run("ovf", 7'b1000000, 1'b0, 4'd14, 10'h1E0, 3'b010, 2);
      run("unf0", 7'b0010000, 1'b1, 4'd0, 10'h000, 3'b001, 2);

      // Back-pressure: hold OUT_READY low four cycles.
      OUT_READY = 1'b0;
      send(7'b0100000, 1'b0, 4'd7);
      wait_out(lat);
      chk("bp_lat", lat, 2);
      TEMP_FRAC   = 7'b1010011;
      RESULT_SIGN = 1'b1;
      EXP_IN      = 4'd5;
      IN_VALID    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         chk("bp_ov", {31'd0, OUT_VALID}, 32'd1);
         chk("bp_res", {22'd0, RESULT}, 32'h0E0);
         chk("bp_rdy", {31'd0, IN_READY}, 32'd0);
      end
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      chk("bp_hs_ov", {31'd0, OUT_VALID}, 32'd0);
      chk("bp_hs_rdy", {31'd0, IN_READY}, 32'd1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      wait_out(lat);
      chk("bp_nx_res", {22'd0, RESULT}, 32'h2C9);
      chk("bp_nx_lat", lat, 3);
      @(posedge CLK);
      #1;

      // Reset pulse while normalizing case 3.
      send(7'b0000101, 1'b0, 4'd9);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      chk("mr_rdy_in", {31'd0, IN_READY}, 32'd0);
      @(posedge CLK);
      #1;
      chk("mr_ov", {31'd0, OUT_VALID}, 32'd0);
      chk("mr_res", {22'd0, RESULT}, 32'd0);
      chk("mr_flg", flags(), 32'd0);
      RST = 1'b0;
      #1;
      chk("mr_rdy_out", {31'd0, IN_READY}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK);
         #1;
         chk("mr_stale", {31'd0, OUT_VALID}, 32'd0);
      end
      run("mr_c1", 7'b0100000, 1'b0, 4'd7, 10'h0E0, 3'b000, 2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
